conv_encoder_punct: RTL

- 802.11a transmitter convolutional encoder.
- Takes the scrambled serial data stream and encodes it with the K=7 code (g0=133 octal, g1=171 octal).
- Applies the standard puncturing for coding rates 1/2, 2/3 or 3/4.
- Emits the coded bits serially in transmission order, with valid/ready handshakes on both sides. It is the transmit-side counterpart of the receiver's Viterbi decoder.

---
 rtl/conv_encoder_punct.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/conv_encoder_punct.sv
// -----------------------------------------------------------------------------
// conv_encoder_punct
//   802.11a transmit convolutional encoder (K=7, g0=133o, g1=171o) with the
//   standard 1/2, 2/3 and 3/4 puncturing. The serial input bit is encoded into
//   two parity bits (A, B), the puncturing pattern keeps one or both of them,
//   and the kept bits are emitted serially (A before B) through a two-entry
//   pending buffer.
//
// Ports
//   Clock     in   clock
//   Reset     in   asynchronous, active-high reset
//   Start     in   synchronous frame start: clears encoder state, latches Rate
//   Rate[1:0] in   00=1/2, 01=2/3, 10=3/4, 11=reserved (behaves as 1/2)
//   InValid   in   Input holds a data bit
//   Input     in   uncoded data bit
//   InReady   out  encoder accepts a bit this cycle (combinational)
//   OutValid  out  Output holds a coded bit
//   Output    out  coded (punctured) bit
//   OutReady  in   downstream consumes Output this cycle
// -----------------------------------------------------------------------------
module conv_encoder_punct #(
  parameter int           K  = 7,
  parameter logic [K-1:0] G0 = 7'b1011011,
  parameter logic [K-1:0] G1 = 7'b1111001
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic       Start,
  input  logic [1:0] Rate,
  input  logic       InValid,
  input  logic       Input,
  output logic       InReady,
  output logic       OutValid,
  output logic       Output,
  input  logic       OutReady
);

  localparam logic [1:0] RATE_1_2 = 2'b00;
  localparam logic [1:0] RATE_2_3 = 2'b01;
  localparam logic [1:0] RATE_3_4 = 2'b10;

  // Parity of the tapped positions of {current bit, s1..s6}.
  function automatic logic tap_parity(input logic [K-1:0] v, input logic [K-1:0] g);
    tap_parity = ^(v & g);
  endfunction

  // r_shift[K-2] is s1 (newest), r_shift[0] is s6 (oldest), so {Input, r_shift}
  // lines up with the generator polynomials whose MSB taps the current bit.
  logic [K-2:0] r_shift;
  logic [1:0]   r_phase;
  logic [1:0]   r_rate;
  logic [1:0]   r_count;
  logic [1:0]   r_buf;

  logic [K-1:0] w_taps;
  logic         w_bit_a;
  logic         w_bit_b;
  logic         w_keep_a;
  logic         w_keep_b;
  logic [1:0]   w_phase_next;
  logic         w_accept;
  logic         w_xfer;
  logic [1:0]   w_buf_next;
  logic [1:0]   w_count_next;

  assign w_taps  = {Input, r_shift};
  assign w_bit_a = tap_parity(w_taps, G0);
  assign w_bit_b = tap_parity(w_taps, G1);

  assign OutValid = (r_count != 2'd0);
  assign Output   = r_buf[0];

  // A new bit is taken only when the buffer is empty or its single bit leaves
  // on this same edge, so the 1-2 new bits always fit.
  assign InReady  = ~Start && ((r_count == 2'd0) || ((r_count == 2'd1) && OutReady));
  assign w_accept = InValid && InReady;
  assign w_xfer   = OutValid && OutReady;

  // Puncturing pattern: which parity bits survive, and the following phase.
  always_comb begin
    w_keep_a     = 1'b1;
    w_keep_b     = 1'b1;
    w_phase_next = 2'd0;
    case (r_rate)
      RATE_2_3: begin
        if (r_phase == 2'd0) begin
          w_phase_next = 2'd1;
        end else begin
          w_keep_b     = 1'b0;
          w_phase_next = 2'd0;
        end
      end
      RATE_3_4: begin
        case (r_phase)
          2'd0: begin
            w_phase_next = 2'd1;
          end
          2'd1: begin
            w_keep_b     = 1'b0;
            w_phase_next = 2'd2;
          end
          2'd2: begin
            w_keep_a     = 1'b0;
            w_phase_next = 2'd0;
          end
          default: begin
            w_phase_next = 2'd0;
          end
        endcase
      end
      RATE_1_2: begin
        w_phase_next = 2'd0;
      end
      default: begin
        w_phase_next = 2'd0;
      end
    endcase
  end

  // Pending buffer update. An accept always finds the buffer empty after this
  // edge (either it was empty or its last bit is transferring), so it simply
  // overwrites buffer and count.
  always_comb begin
    w_buf_next   = r_buf;
    w_count_next = r_count;
    if (w_accept) begin
      if (w_keep_a && w_keep_b) begin
        w_buf_next   = {w_bit_b, w_bit_a};
        w_count_next = 2'd2;
      end else if (w_keep_a) begin
        w_buf_next   = {1'b0, w_bit_a};
        w_count_next = 2'd1;
      end else begin
        w_buf_next   = {1'b0, w_bit_b};
        w_count_next = 2'd1;
      end
    end else if (w_xfer) begin
      w_buf_next   = {1'b0, r_buf[1]};
      w_count_next = r_count - 2'd1;
    end else begin
      w_buf_next   = r_buf;
      w_count_next = r_count;
    end
  end

  // Encoder state: Start wins over any accept or transfer in its cycle.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      r_shift <= {(K-1){1'b0}};
      r_phase <= 2'd0;
      r_rate  <= RATE_1_2;
      r_count <= 2'd0;
      r_buf   <= 2'b00;
    end else if (Start) begin
      r_shift <= {(K-1){1'b0}};
      r_phase <= 2'd0;
      r_rate  <= (Rate == 2'b11) ? RATE_1_2 : Rate;
      r_count <= 2'd0;
      r_buf   <= 2'b00;
    end else begin
      r_count <= w_count_next;
      r_buf   <= w_buf_next;
      if (w_accept) begin
        r_shift <= {Input, r_shift[K-2:1]};
        r_phase <= w_phase_next;
      end
    end
  end

endmodule
